// File: rtl/core_bus_scanner.sv
// Slice-serial bridge: assembles LENGTH-bit core input frames from 8-bit slices,
// steps the core once per frame and snapshots its outputs for byte-wise readback.
module core_bus_scanner #(
    parameter  int LENGTH = 16,
    localparam int N      = LENGTH / 8,
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_in_valid,
    input  logic              sync,
    output logic [7:0]        byte_out,
    output logic [IDX_W-1:0]  slice_idx,
    output logic              busy,
    output logic              overrun,
    output logic [7:0]        frame_count,
    output logic [LENGTH-1:0] core_in,
    output logic              core_ce,
    input  logic [LENGTH-1:0] core_obs
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_STEP = 2'd1,
        S_SNAP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, eff_idx;
    logic [LENGTH-1:0] shadow_q, shadow_d;
    logic [LENGTH-1:0] obs_shadow_q, obs_shadow_d;
    logic [LENGTH-1:0] core_in_q, core_in_d;
    logic [7:0]        frame_count_q, frame_count_d;
    logic              overrun_q, overrun_d;
    logic              core_ce_q;
    logic              accept;
    logic              last_slice;
    logic [N-1:0]      slice_wr;
    logic [7:0]        obs_bytes [N];

    assign accept     = (state_q == S_FILL) && byte_in_valid;
    // sync takes the index back to slice 0 even when a byte arrives with it
    assign eff_idx    = sync ? '0 : idx_q;
    assign last_slice = (eff_idx == IDX_W'(N - 1));

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign slice_wr[gi]          = accept && (eff_idx == IDX_W'(gi));
            assign shadow_d[gi*8 +: 8]   = slice_wr[gi] ? byte_in : shadow_q[gi*8 +: 8];
            assign obs_bytes[gi]         = obs_shadow_q[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        core_in_d     = core_in_q;
        obs_shadow_d  = obs_shadow_q;
        frame_count_d = frame_count_q;
        overrun_d     = overrun_q;
        unique case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (last_slice) begin
                        core_in_d = shadow_d;
                        idx_d     = '0;
                        state_d   = S_STEP;
                    end else begin
                        idx_d = eff_idx + IDX_W'(1);
                    end
                end else if (sync) begin
                    idx_d = '0;
                end
            end
            S_STEP: begin
                overrun_d = overrun_q | byte_in_valid;
                state_d   = S_SNAP;
            end
            S_SNAP: begin
                overrun_d     = overrun_q | byte_in_valid;
                obs_shadow_d  = core_obs;
                frame_count_d = frame_count_q + 8'd1;
                state_d       = S_FILL;
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FILL;
            idx_q         <= '0;
            shadow_q      <= '0;
            obs_shadow_q  <= '0;
            core_in_q     <= '0;
            core_ce_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            obs_shadow_q  <= obs_shadow_d;
            core_in_q     <= core_in_d;
            core_ce_q     <= (state_d == S_STEP);
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign byte_out    = obs_bytes[idx_q];
    assign slice_idx   = idx_q;
    assign busy        = (state_q != S_FILL);
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;
    assign core_in     = core_in_q;
    assign core_ce     = core_ce_q;

endmodule

// File: tb/tb_core_bus_scanner.sv
// Bench for core_bus_scanner: a 16-bit and an 8-bit instance, each with a core
// model (obs = in + 1 on core_ce) and a scoreboard of expected committed frames.
module tb_core_bus_scanner;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // 16-bit instance
    logic [7:0]  byte_in;
    logic        byte_in_valid, sync;
    logic [7:0]  byte_out;
    logic [0:0]  slice_idx;
    logic        busy, overrun, core_ce;
    logic [7:0]  frame_count;
    logic [15:0] core_in, core_obs;

    // 8-bit instance
    logic [7:0]  b8;
    logic        v8, s8;
    logic [7:0]  bo8;
    logic [0:0]  si8;
    logic        busy8, ovr8, ce8;
    logic [7:0]  fc8;
    logic [7:0]  ci8, obs8;

    int errors = 0;
    int checks = 0;
    int ce_count = 0;
    int ce8_count = 0;
    bit ce_prev = 1'b0;
    logic [15:0] exp_q [$];
    logic [7:0]  exp8_q [$];

    core_bus_scanner #(.LENGTH(16)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_in_valid(byte_in_valid), .sync(sync),
        .byte_out(byte_out), .slice_idx(slice_idx), .busy(busy), .overrun(overrun),
        .frame_count(frame_count), .core_in(core_in), .core_ce(core_ce), .core_obs(core_obs)
    );

    core_bus_scanner #(.LENGTH(8)) dut8 (
        .clk(clk), .rst(rst), .byte_in(b8), .byte_in_valid(v8), .sync(s8),
        .byte_out(bo8), .slice_idx(si8), .busy(busy8), .overrun(ovr8),
        .frame_count(fc8), .core_in(ci8), .core_ce(ce8), .core_obs(obs8)
    );

    // Core models: register core_in + 1 on each enabled clock
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_obs <= 16'd0;
            obs8     <= 8'd0;
        end else begin
            if (core_ce) core_obs <= core_in + 16'd1;
            if (ce8)     obs8     <= ci8 + 8'd1;
        end
    end

    // Scoreboard: every core_ce pulse must present the next expected frame
    always @(negedge clk) begin
        if (core_ce) begin
            ce_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb16_unexpected_ce: core_in=%h with no frame expected", core_in);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (core_in !== e) begin
                    errors++;
                    $display("FAIL sb16_core_in: got %h expected %h", core_in, e);
                end else $display("frame16 core_in=%h ok", core_in);
            end
            if (ce_prev) begin
                errors++;
                $display("FAIL ce16_width: core_ce high two cycles in a row");
            end
        end
        ce_prev = core_ce;
        if (ce8) begin
            ce8_count++;
            checks++;
            if (exp8_q.size() == 0) begin
                errors++;
                $display("FAIL sb8_unexpected_ce: core_in=%h with no frame expected", ci8);
            end else begin
                logic [7:0] e8;
                e8 = exp8_q.pop_front();
                if (ci8 !== e8) begin
                    errors++;
                    $display("FAIL sb8_core_in: got %h expected %h", ci8, e8);
                end else $display("frame8 core_in=%h ok", ci8);
            end
        end
    end

    // Apply inputs just after a falling edge and wait for the next falling edge
    task automatic drive(input logic v, input logic [7:0] b, input logic s);
        byte_in_valid = v; byte_in = b; sync = s;
        @(negedge clk);
    endtask

    task automatic drive8(input logic v, input logic [7:0] b, input logic s);
        v8 = v; b8 = b; s8 = s;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        byte_in = 8'd0; byte_in_valid = 1'b0; sync = 1'b0;
        b8 = 8'd0; v8 = 1'b0; s8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({core_in, byte_out, slice_idx, busy, overrun, frame_count, core_ce} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: core_in=%h byte_out=%h idx=%0d busy=%b ovr=%b fc=%0d ce=%b, all required 0",
                     core_in, byte_out, slice_idx, busy, overrun, frame_count, core_ce);
        end else $display("reset state ok");
    endtask

    task automatic test_basic;
        drive(1'b1, 8'h34, 1'b0);
        checks++;
        if (slice_idx !== 1'd1) begin errors++; $display("FAIL basic_idx1: got %0d expected 1", slice_idx); end
        exp_q.push_back(16'h1234);
        drive(1'b1, 8'h12, 1'b0);
        checks++;
        if (core_in !== 16'h1234 || core_ce !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_t1: core_in=%h ce=%b busy=%b expected 1234 1 1", core_in, core_ce, busy);
        end
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (core_ce !== 1'b0 || busy !== 1'b1 || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL basic_t2: ce=%b busy=%b fc=%0d expected 0 1 0", core_ce, busy, frame_count);
        end
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (busy !== 1'b0 || frame_count !== 8'd1 || byte_out !== 8'h35 || slice_idx !== 1'd0) begin
            errors++;
            $display("FAIL basic_t3: busy=%b fc=%0d byte_out=%h idx=%0d expected 0 1 35 0",
                     busy, frame_count, byte_out, slice_idx);
        end
        drive(1'b1, 8'h00, 1'b0);
        checks++;
        if (byte_out !== 8'h12) begin errors++; $display("FAIL basic_readback1: got %h expected 12", byte_out); end
        exp_q.push_back(16'h0000);
        drive(1'b1, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        $display("basic done fc=%0d", frame_count);
    endtask

    task automatic test_sync;
        int ce0;
        ce0 = ce_count;
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (slice_idx !== 1'd0) begin errors++; $display("FAIL sync_idx0: got %0d expected 0", slice_idx); end
        exp_q.push_back(16'h0201);
        drive(1'b1, 8'h01, 1'b0);
        drive(1'b1, 8'h02, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (ce_count != ce0 + 1) begin errors++; $display("FAIL sync_ce_count: got %0d expected %0d", ce_count - ce0, 1); end
        exp_q.push_back(16'h6677);
        drive(1'b1, 8'h77, 1'b1);
        checks++;
        if (slice_idx !== 1'd1) begin errors++; $display("FAIL sync_valid_idx: got %0d expected 1", slice_idx); end
        drive(1'b1, 8'h66, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (byte_out !== 8'h78) begin errors++; $display("FAIL sync_readback: got %h expected 78", byte_out); end
        $display("sync done");
    endtask

    task automatic test_overrun;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre: got %b expected 0", overrun); end
        exp_q.push_back(16'h2211);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        drive(1'b1, 8'h44, 1'b0);
        checks++;
        if (overrun !== 1'b1 || slice_idx !== 1'd0) begin
            errors++;
            $display("FAIL ovr_set: ovr=%b idx=%0d expected 1 0", overrun, slice_idx);
        end
        exp_q.push_back(16'h6655);
        drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'h66, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (overrun !== 1'b1 || byte_out !== 8'h56) begin
            errors++;
            $display("FAIL ovr_sticky: ovr=%b byte_out=%h expected 1 56", overrun, byte_out);
        end
        $display("overrun done");
    endtask

    task automatic test_reset_midframe;
        int ce0;
        ce0 = ce_count;
        drive(1'b1, 8'h9A, 1'b0);
        byte_in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({core_in, byte_out, slice_idx, busy, overrun, frame_count, core_ce} !== 35'd0) begin
            errors++;
            $display("FAIL midreset_state: core_in=%h byte_out=%h idx=%0d busy=%b ovr=%b fc=%0d ce=%b, all required 0",
                     core_in, byte_out, slice_idx, busy, overrun, frame_count, core_ce);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        checks++;
        if (ce_count != ce0) begin errors++; $display("FAIL midreset_ce: got %0d pulses expected 0", ce_count - ce0); end
        $display("mid-frame reset done");
    endtask

    task automatic test_wrap;
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            exp_q.push_back({~b, b});
            drive(1'b1, b, 1'b0);
            drive(1'b1, ~b, 1'b0);
            drive(1'b0, 8'h00, 1'b0);
            drive(1'b0, 8'h00, 1'b0);
            if (i == 254) begin
                checks++;
                if (frame_count !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", frame_count); end
            end
        end
        checks++;
        if (frame_count !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", frame_count); end
        $display("wrap done fc=%0d", frame_count);
    endtask

    task automatic test_len8;
        logic [7:0] b;
        for (int k = 0; k < 6; k++) begin
            b = 8'hC0 + 8'(k);
            if (k % 3 == 0) exp8_q.push_back(b);
            drive8(1'b1, b, 1'b0);
            checks++;
            if (si8 !== 1'd0) begin errors++; $display("FAIL len8_idx: got %0d expected 0", si8); end
        end
        exp8_q.push_back(8'h5A);
        drive8(1'b1, 8'h5A, 1'b1);
        repeat (3) drive8(1'b0, 8'h00, 1'b0);
        checks++;
        if (ce8_count != 3 || fc8 !== 8'd3 || ovr8 !== 1'b1 || bo8 !== 8'h5B) begin
            errors++;
            $display("FAIL len8_summary: ce=%0d fc=%0d ovr=%b byte_out=%h expected 3 3 1 5b",
                     ce8_count, fc8, ovr8, bo8);
        end
        $display("len8 done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sync();
        test_overrun();
        test_reset_midframe();
        test_wrap();
        test_len8();
        checks++;
        if (exp_q.size() != 0 || exp8_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d/%0d frames never committed, expected 0", exp_q.size(), exp8_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within the time limit");
        $fatal(1);
    end

endmodule
